regwb_arbiter: RTL

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_arbiter.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/regwb_arbiter.sv
//------------------------------------------------------------------------------
// Module      : regwb_arbiter
// Description : Register-file write-back arbiter. Merges the execute-stage
//               (E) and memory-stage (M) write requests onto the single
//               register-file write port. Each side owns a one-entry buffer.
//               Contention between different registers alternates grants.
//               Contention on the same register keeps the M value and drops
//               the E entry.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports
//   clock         : single clock, rising-edge active
//   reset_n       : asynchronous active-low reset
//   validE/regE/valueE : execute-stage write request (dstE/valE)
//   readyE        : E request accepted on the edge where validE && readyE
//   validM/regM/valueM : memory-stage write request (dstM/valM)
//   readyM        : M-side handshake, same rules as readyE
//   write1/register1/value1 : register-file write port, combinational
//   dropE         : one-cycle pulse when a buffered E entry is discarded
//   readReg1/bypassHit1/bypassValue1 : forwarding lookup into the buffers
//                   (only present when REGWB_BYPASS_EN is defined)
//
// Build option
//   REGWB_BYPASS_EN : adds the buffer-forwarding lookup port
//------------------------------------------------------------------------------
`default_nettype none

module regwb_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    // Execute-stage request
    input  logic        validE,
    input  logic [3:0]  regE,
    input  logic [31:0] valueE,
    output logic        readyE,
    // Memory-stage request
    input  logic        validM,
    input  logic [3:0]  regM,
    input  logic [31:0] valueM,
    output logic        readyM,
    // Register-file write port
    output logic        write1,
    output logic [3:0]  register1,
    output logic [31:0] value1,
    output logic        dropE
`ifdef REGWB_BYPASS_EN
    ,
    input  logic [3:0]  readReg1,
    output logic        bypassHit1,
    output logic [31:0] bypassValue1
`endif
);

    // "No register" id: a request naming it is consumed without a write
    localparam logic [3:0] c_RNONE = 4'hF;

    // lastGrant encoding
    localparam logic [0:0] GRANT_E = 1'b0;
    localparam logic [0:0] GRANT_M = 1'b1;

    //--------------------------------------------------------------------------
    // State: two buffer entries plus the last-granted side
    //--------------------------------------------------------------------------
    logic        r_fullE;
    logic [3:0]  r_regE;
    logic [31:0] r_valE;
    logic        r_fullM;
    logic [3:0]  r_regM;
    logic [31:0] r_valM;
    logic [0:0]  r_lastGrant;

    logic        w_fullE_nxt;
    logic [3:0]  w_regE_nxt;
    logic [31:0] w_valE_nxt;
    logic        w_fullM_nxt;
    logic [3:0]  w_regM_nxt;
    logic [31:0] w_valM_nxt;
    logic [0:0]  w_lastGrant_nxt;

    // Arbitration decision for the current cycle
    logic        w_grantE;
    logic        w_grantM;
    logic        w_collide;
    logic        w_drainE;
    logic        w_drainM;

    // Handshake
    logic        w_accE;
    logic        w_accM;
    logic        w_fillE;
    logic        w_fillM;

    //--------------------------------------------------------------------------
    // Process 1: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fullE     <= 1'b0;
            r_regE      <= 4'h0;
            r_valE      <= 32'h0;
            r_fullM     <= 1'b0;
            r_regM      <= 4'h0;
            r_valM      <= 32'h0;
            r_lastGrant <= GRANT_M;
        end else begin
            r_fullE     <= w_fullE_nxt;
            r_regE      <= w_regE_nxt;
            r_valE      <= w_valE_nxt;
            r_fullM     <= w_fullM_nxt;
            r_regM      <= w_regM_nxt;
            r_valM      <= w_valM_nxt;
            r_lastGrant <= w_lastGrant_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Process 2: next-state logic
    //--------------------------------------------------------------------------
    // A side is ready when its buffer is empty or is being drained this cycle,
    // which lets a drain and a refill happen on the same edge.
    assign readyE  = !r_fullE || w_drainE;
    assign readyM  = !r_fullM || w_drainM;

    assign w_accE  = validE && readyE;
    assign w_accM  = validM && readyM;
    // RNONE requests complete the handshake but never occupy the buffer
    assign w_fillE = w_accE && (regE != c_RNONE);
    assign w_fillM = w_accM && (regM != c_RNONE);

    always_comb begin
        w_fullE_nxt     = r_fullE;
        w_regE_nxt      = r_regE;
        w_valE_nxt      = r_valE;
        w_fullM_nxt     = r_fullM;
        w_regM_nxt      = r_regM;
        w_valM_nxt      = r_valM;
        w_lastGrant_nxt = r_lastGrant;

        // Drain first; a same-cycle fill below takes priority over the clear
        if (w_drainE) begin
            w_fullE_nxt = 1'b0;
        end
        if (w_drainM) begin
            w_fullM_nxt = 1'b0;
        end

        if (w_fillE) begin
            w_fullE_nxt = 1'b1;
            w_regE_nxt  = regE;
            w_valE_nxt  = valueE;
        end
        if (w_fillM) begin
            w_fullM_nxt = 1'b1;
            w_regM_nxt  = regM;
            w_valM_nxt  = valueM;
        end

        if (w_grantM) begin
            w_lastGrant_nxt = GRANT_M;
        end else if (w_grantE) begin
            w_lastGrant_nxt = GRANT_E;
        end
    end

    //--------------------------------------------------------------------------
    // Process 3: output logic (arbitration and write port)
    //--------------------------------------------------------------------------
    always_comb begin
        w_grantE  = 1'b0;
        w_grantM  = 1'b0;
        w_collide = 1'b0;

        if (r_fullE && r_fullM) begin
            if (r_regE == r_regM) begin
                // Same destination: the later pipeline stage wins and the
                // older E value is obsolete, so both entries retire at once.
                w_grantM  = 1'b1;
                w_collide = 1'b1;
            end else if (r_lastGrant == GRANT_M) begin
                w_grantE  = 1'b1;
            end else begin
                w_grantM  = 1'b1;
            end
        end else if (r_fullE) begin
            w_grantE = 1'b1;
        end else if (r_fullM) begin
            w_grantM = 1'b1;
        end
    end

    assign w_drainE = w_grantE || w_collide;
    assign w_drainM = w_grantM;

    assign write1    = w_grantE || w_grantM;
    assign register1 = w_grantM ? r_regM : (w_grantE ? r_regE : 4'h0);
    assign value1    = w_grantM ? r_valM : (w_grantE ? r_valE : 32'h0);
    assign dropE     = w_collide;

`ifdef REGWB_BYPASS_EN
    //--------------------------------------------------------------------------
    // Forwarding lookup: a buffered value is newer than the register file.
    // M is the younger producer, so it wins when both buffers match.
    //--------------------------------------------------------------------------
    logic w_hitE;
    logic w_hitM;

    assign w_hitE       = (readReg1 != c_RNONE) && r_fullE && (r_regE == readReg1);
    assign w_hitM       = (readReg1 != c_RNONE) && r_fullM && (r_regM == readReg1);
    assign bypassHit1   = w_hitE || w_hitM;
    assign bypassValue1 = w_hitM ? r_valM : (w_hitE ? r_valE : 32'h0);
`endif

endmodule

`default_nettype wire
